cnn_pool_flatten: RTL and testbench
===================================

Name: cnn_pool_flatten

Overview:
- Layer-1/Layer-2 stage of the CNN accelerator. It sits directly downstream of the layer-0 convolution engine and consumes the layer-0 feature maps.
- Reads the two 64x64 layer-0 maps (kernel 0 and kernel 1) through the shared csel memory bus.
- Applies 2x2 stride-2 max-pooling and writes the two 32x32 layer-1 maps.
- Writes the interleaved 2048-entry flatten map (layer 2) at the same time.

Parameters:
- DATA_W, 20, fixed-point sample width (4 integer bits . 16 fraction bits).
- FRAC_W, 16, fraction bits; used by the rounding option.
- IMG_W, 64, layer-0 map width/height; pooled width is IMG_W/2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled in IDLE to launch one full pass.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last layer-2 write.
- crd  out  1  read strobe to the layer memories.
- caddr_rd  out  12  read address.
- cdata_rd  in  20  read data; valid at the rising edge following the edge that issued crd/caddr_rd (one-cycle latency).
- cwr  out  1  write strobe; memory captures the write on the rising edge.
- caddr_wr  out  12  write address.
- cdata_wr  out  20  write data.
- csel  out  3  memory select: 001 L0 k0, 010 L0 k1, 011 L1 k0, 100 L1 k1, 101 L2.

Behaviour:
- Reset (asynchronous): FSM to IDLE, o=0, k=0, max register cleared.
  - busy, done, crd and cwr are 0.
  - csel, caddr_rd, caddr_wr and cdata_wr are 0.
  - A reset mid-pass aborts the pass with no further writes; a new start is required.
- Indices:
  - o = 0..1023 is the pooled index; row = o[9:5], col = o[4:0].
  - k = 0..1 is the kernel.
  - base = row*128 + col*2.
  - Window addresses: base, base+1, base+64, base+65 (12-bit, no wrap possible).
- FSM states: IDLE, RD0, RD1, RD2, RD3, CMP, WL1, WL2, DONE.
- IDLE: when start=1, go to RD0 with o=0, k=0, and raise busy. start is ignored in every other state.
- RD0: crd=1, csel = (k ? 010 : 001), caddr_rd = base.
- RD1..RD3:
  - crd=1, same csel, caddr_rd = base+1, base+64, base+65 respectively.
  - Capture cdata_rd into the max register: RD1 loads it; RD2 and RD3 load max(max, cdata_rd).
- CMP: crd=0; max = max(max, cdata_rd), which is the 4th sample.
- WL1: cwr=1, csel = (k ? 100 : 011), caddr_wr = o, cdata_wr = pooled value.
- WL2: cwr=1, csel=101, caddr_wr = 2*o + k, cdata_wr = same pooled value.
  - If k=0: set k=1 and go to RD0.
  - Else if o=1023: go to DONE.
  - Else: set k=0, o=o+1 and go to RD0.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Output discipline:
  - crd and cwr are never high in the same cycle.
  - Outputs are driven from registered state only; no combinational path from cdata_rd to any output.
- Comparison: unsigned 20-bit compare (layer-0 data is post-ReLU, so never negative). Ties keep the earlier sample, which gives the identical value.
- Latency: 7 cycles per (o,k), so a full pass takes 2048*7 + 2 = 14338 cycles from start to done.

Optional Feature:
- Macro: CNN_POOL_CEIL_EN.
- Defined: pooled value is rounded up to an integer.
  - If the fraction bits are non-zero, result = {int+1, 16'h0}.
  - If int=4'hF with a non-zero fraction, result saturates to 20'hF0000.
  - Applies to both L1 and L2 writes.
- Undefined: the raw maximum is written unchanged.

Decomposition:
- Shared package cnn_pkg:
  - csel encodings (CSEL_L0K0..CSEL_L2).
  - DATA_W and IMG_W constants.
  - FSM state enum.
- One sub-module, cnn_pool_max_round: combinational max(a,b) plus the optional ceil/saturate of the final value. It holds the only arithmetic in the block.

Test Plan:
- Reset asserted during RD2 of o=5 -> all outputs 0 within the same cycle; no further cwr; a later start restarts from o=0 and the pass completes.
- Window values 00010,0A000,20000,1FFFF at L0 k0 addr 0,1,64,65 -> L1 k0[0] = 20000 and L2[0] = 20000.
- L0 k1 window 1_8000,0,0,0 at o=1023 (addr 4030,4031,4094,4095):
  - Without CNN_POOL_CEIL_EN -> L1 k1[1023] = L2[2047] = 18000 (hex, fraction bits non-zero).
  - With CNN_POOL_CEIL_EN -> both = 20000.
  - In both cases done pulses exactly once.
- With CNN_POOL_CEIL_EN, window max F0001 -> saturated F0000. Window max 30000 (no fraction) -> unchanged 30000.
- Full pass on the random pattern vs golden L1/L2 files -> 0 mismatches.
  - busy high for exactly 14337 cycles.
  - Write order check: L1 k0, L2 even, L1 k1, L2 odd per o.
  - start held high for the whole pass -> exactly one pass, then a second pass begins only after returning to IDLE.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the pooling/flatten stage: data geometry, csel memory
// encodings and the sequencer state encoding.
package cnn_pkg;

  localparam int DATA_W = 20;
  localparam int FRAC_W = 16;
  localparam int IMG_W  = 64;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CMP, S_WL1, S_WL2, S_DONE
  } state_t;

endpackage

// File: rtl/cnn_pool_max_round.sv
// Unsigned max of two samples plus the pooled output value. With CNN_POOL_CEIL_EN
// defined, the pooled value is rounded up to an integer (saturating at 4'hF).
module cnn_pool_max_round #(
  parameter int DATA_W = 20,
  parameter int FRAC_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] max_ab,
  output logic [DATA_W-1:0] pooled
);

  // A tie keeps a; the value is identical either way.
  assign max_ab = (b > a) ? b : a;

`ifdef CNN_POOL_CEIL_EN
  localparam int INT_W = DATA_W - FRAC_W;

  logic [INT_W-1:0]  int_part;
  logic [INT_W-1:0]  int_inc;
  logic [FRAC_W-1:0] frac_part;

  assign int_part  = max_ab[DATA_W-1:FRAC_W];
  assign frac_part = max_ab[FRAC_W-1:0];
  assign int_inc   = int_part + INT_W'(1);

  always_comb begin
    if (frac_part == '0)
      pooled = max_ab;
    else if (&int_part)
      pooled = {int_part, {FRAC_W{1'b0}}};
    else
      pooled = {int_inc, {FRAC_W{1'b0}}};
  end
`else
  assign pooled = max_ab;
`endif

endmodule

// File: rtl/cnn_pool_flatten.sv
// Layer-1/2 stage: 2x2 max-pools both 64x64 layer-0 maps into the 32x32 layer-1
// maps and the interleaved flatten map. Optional ceil rounding: CNN_POOL_CEIL_EN.
module cnn_pool_flatten #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int FRAC_W = cnn_pkg::FRAC_W,
  parameter int IMG_W  = cnn_pkg::IMG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [11:0]       caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [11:0]       caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);

  import cnn_pkg::state_t, cnn_pkg::S_IDLE, cnn_pkg::S_RD0, cnn_pkg::S_RD1,
         cnn_pkg::S_RD2, cnn_pkg::S_RD3, cnn_pkg::S_CMP, cnn_pkg::S_WL1,
         cnn_pkg::S_WL2, cnn_pkg::S_DONE, cnn_pkg::CSEL_NONE, cnn_pkg::CSEL_L0K0,
         cnn_pkg::CSEL_L0K1, cnn_pkg::CSEL_L1K0, cnn_pkg::CSEL_L1K1, cnn_pkg::CSEL_L2;

  localparam int POOL_W = IMG_W / 2;
  localparam int O_W    = $clog2(POOL_W * POOL_W);

  state_t            state;
  logic [O_W-1:0]    o;
  logic              k;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] max_ab;
  logic [DATA_W-1:0] pooled;
  logic [O_W-1:0]    o_next;
  logic [11:0]       cur_base;
  logic [11:0]       nxt_base;

  // Top-left layer-0 address of the 2x2 window for pooled index idx.
  function automatic logic [11:0] win_base(input logic [O_W-1:0] idx);
    int row, col;
    row = 32'(idx) / POOL_W;
    col = 32'(idx) % POOL_W;
    return 12'(row * 2 * IMG_W + col * 2);
  endfunction

  assign o_next   = o + O_W'(1);
  assign cur_base = win_base(o);
  assign nxt_base = win_base(o_next);

  cnn_pool_max_round #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_max (
    .a      (max_q),
    .b      (cdata_rd),
    .max_ab (max_ab),
    .pooled (pooled)
  );

  // NOTE: every output is a flop loaded on the transition INTO the state that
  // owns it, so the bus sees the per-state values with no combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      o        <= '0;
      k        <= 1'b0;
      max_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= CSEL_NONE;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          state    <= S_RD0;
          o        <= '0;
          k        <= 1'b0;
          busy     <= 1'b1;
          crd      <= 1'b1;
          csel     <= CSEL_L0K0;
          caddr_rd <= win_base('0);
        end
        S_RD0: begin
          state    <= S_RD1;
          caddr_rd <= cur_base + 12'd1;
        end
        S_RD1: begin
          state    <= S_RD2;
          caddr_rd <= cur_base + 12'(IMG_W);
          max_q    <= cdata_rd;
        end
        S_RD2: begin
          state    <= S_RD3;
          caddr_rd <= cur_base + 12'(IMG_W + 1);
          max_q    <= max_ab;
        end
        S_RD3: begin
          state <= S_CMP;
          crd   <= 1'b0;
          max_q <= max_ab;
        end
        S_CMP: begin
          state    <= S_WL1;
          max_q    <= max_ab;
          cwr      <= 1'b1;
          csel     <= k ? CSEL_L1K1 : CSEL_L1K0;
          caddr_wr <= 12'(o);
          cdata_wr <= pooled;
        end
        S_WL1: begin
          state    <= S_WL2;
          csel     <= CSEL_L2;
          caddr_wr <= 12'({o, k});
        end
        S_WL2: begin
          cwr <= 1'b0;
          if (!k) begin
            state    <= S_RD0;
            k        <= 1'b1;
            crd      <= 1'b1;
            csel     <= CSEL_L0K1;
            caddr_rd <= cur_base;
          end else if (&o) begin
            state <= S_DONE;
            done  <= 1'b1;
            csel  <= CSEL_NONE;
          end else begin
            state    <= S_RD0;
            k        <= 1'b0;
            o        <= o_next;
            crd      <= 1'b1;
            csel     <= CSEL_L0K0;
            caddr_rd <= nxt_base;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_pool_flatten.sv
// Scoreboard bench for cnn_pool_flatten: layer-0 memory model, expected write
// stream queued per pass and compared in order as the DUT writes.
module tb_cnn_pool_flatten;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd = '0;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;

  always #5 clk = ~clk;

  cnn_pool_flatten dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

`ifdef CNN_POOL_CEIL_EN
  localparam logic [19:0] EXP_O1023 = 20'h20000;
  localparam logic [19:0] EXP_O1    = 20'hF0000;
  localparam logic [19:0] EXP_O3    = 20'h20000;
`else
  localparam logic [19:0] EXP_O1023 = 20'h18000;
  localparam logic [19:0] EXP_O1    = 20'hF0001;
  localparam logic [19:0] EXP_O3    = 20'h12345;
`endif

  logic [19:0] l0k0 [4096];
  logic [19:0] l0k1 [4096];
  logic [19:0] l1k0 [1024];
  logic [19:0] l1k1 [1024];
  logic [19:0] l2   [2048];
  logic [34:0] exp_q [$];
  logic [34:0] exp_wr;

  int n_checks = 0, n_errors = 0;
  int n_writes = 0, n_done = 0, n_overlap = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [50:0] outs();
    return {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr};
  endfunction

  function automatic logic [19:0] max2(input logic [19:0] a, input logic [19:0] b);
    return (a >= b) ? a : b;
  endfunction

  function automatic logic [19:0] ceil_ref(input logic [19:0] v);
`ifdef CNN_POOL_CEIL_EN
    if (v[15:0] == 16'h0) return v;
    if (v[19:16] == 4'hF) return 20'hF0000;
    return {v[19:16] + 4'd1, 16'h0};
`else
    return v;
`endif
  endfunction

  // Queue the full expected write stream of one pass, in bus order.
  task automatic push_pass();
    for (int o = 0; o < 1024; o++) begin
      for (int k = 0; k < 2; k++) begin
        int base;
        logic [19:0] m;
        base = (o / 32) * 128 + (o % 32) * 2;
        if (k == 0)
          m = max2(max2(l0k0[base], l0k0[base+1]), max2(l0k0[base+64], l0k0[base+65]));
        else
          m = max2(max2(l0k1[base], l0k1[base+1]), max2(l0k1[base+64], l0k1[base+65]));
        m = ceil_ref(m);
        exp_q.push_back({(k == 0) ? 3'b011 : 3'b100, 12'(o), m});
        exp_q.push_back({3'b101, 12'(2 * o + k), m});
      end
    end
  endtask

  // Layer-0 memory: one-cycle read latency.
  always @(posedge clk) begin
    if (crd) begin
      case (csel)
        3'b001:  cdata_rd <= l0k0[caddr_rd];
        3'b010:  cdata_rd <= l0k1[caddr_rd];
        default: cdata_rd <= 20'hBAD00;
      endcase
    end
  end

  // Write monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (crd && cwr) n_overlap++;
    if (done) n_done++;
    if (cwr) begin
      n_writes++;
      case (csel)
        3'b011:  l1k0[caddr_wr[9:0]] = cdata_wr;
        3'b100:  l1k1[caddr_wr[9:0]] = cdata_wr;
        3'b101:  l2[caddr_wr[10:0]] = cdata_wr;
        default: ;
      endcase
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_wr = exp_q.pop_front();
        check("write", {29'd0, csel, caddr_wr, cdata_wr}, {29'd0, exp_wr});
      end
    end
  end

  initial begin
    bit found;
    int bc;

    for (int i = 0; i < 4096; i++) begin
      l0k0[i] = 20'($urandom());
      l0k1[i] = 20'($urandom());
    end
    l0k0[0]  = 20'h00010; l0k0[1]  = 20'h0A000; l0k0[64] = 20'h20000; l0k0[65] = 20'h1FFFF;
    l0k0[2]  = 20'hF0001; l0k0[3]  = 20'h0;     l0k0[66] = 20'h0;     l0k0[67] = 20'h0;
    l0k0[4]  = 20'h30000; l0k0[5]  = 20'h10000; l0k0[68] = 20'h2FFFF; l0k0[69] = 20'h0;
    l0k0[6]  = 20'h12345; l0k0[7]  = 20'h12345; l0k0[70] = 20'h12345; l0k0[71] = 20'h12345;
    l0k1[4030] = 20'h18000; l0k1[4031] = 20'h0; l0k1[4094] = 20'h0; l0k1[4095] = 20'h0;

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs()), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", 64'(outs()), 64'd0);

    // Abort a pass with reset during RD2 of o=5 (k=0).
    push_pass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (crd && csel == 3'b001 && caddr_rd == 12'd74) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_rd2_o5", 64'(found), 64'd1);
    reset = 1'b1;
    #1;
    check("reset_async_outputs", 64'(outs()), 64'd0);
    check("writes_before_abort", 64'(n_writes), 64'd20);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("no_write_after_abort", 64'(n_writes), 64'd20);
    check("no_auto_restart", 64'(busy), 64'd0);
    exp_q.delete();
    n_writes = 0;
    n_done = 0;

    // Full pass with start held high: expect two back-to-back passes only.
    push_pass();
    push_pass();
    start = 1'b1;
    bc = 0;
    found = 1'b0;
    for (int c = 0; c < 16000; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    #1;
    check("pass1_done", 64'(found), 64'd1);
    check("busy_cycles", 64'(bc), 64'd14337);
    check("done_pulses_pass1", 64'(n_done), 64'd1);
    check("queue_after_pass1", 64'(exp_q.size()), 64'd4096);
    check("l1k0_0", 64'(l1k0[0]), 64'h20000);
    check("l2_0", 64'(l2[0]), 64'h20000);
    check("l1k1_1023", 64'(l1k1[1023]), 64'(EXP_O1023));
    check("l2_2047", 64'(l2[2047]), 64'(EXP_O1023));
    check("l1k0_1_sat", 64'(l1k0[1]), 64'(EXP_O1));
    check("l2_2_sat", 64'(l2[2]), 64'(EXP_O1));
    check("l1k0_2_int", 64'(l1k0[2]), 64'h30000);
    check("l1k0_3_tie", 64'(l1k0[3]), 64'(EXP_O3));

    @(negedge clk);
    check("idle_gap_busy", 64'(busy), 64'd0);
    check("idle_gap_done", 64'(done), 64'd0);
    @(negedge clk);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_read", 64'({crd, csel, caddr_rd}), 64'({1'b1, 3'b001, 12'd0}));
    start = 1'b0;

    found = 1'b0;
    for (int c = 0; c < 16000; c++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    #1;
    check("pass2_done", 64'(found), 64'd1);
    check("queue_after_pass2", 64'(exp_q.size()), 64'd0);
    repeat (20) @(negedge clk);
    check("done_total", 64'(n_done), 64'd2);
    check("idle_after_pass2", 64'(busy), 64'd0);
    check("no_rd_wr_overlap", 64'(n_overlap), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
